// File: rtl/vga_pkg.sv
// Shared VGA definitions: display geometry defaults, default palette colours,
// the fill-engine state encoding and framebuffer address arithmetic.
package vga_pkg;

  localparam int H_VALID_DEF = 640;
  localparam int V_VALID_DEF = 480;

  localparam logic [11:0] RED    = 12'hf00;
  localparam logic [11:0] ORANGE = 12'hf80;
  localparam logic [11:0] YELLOW = 12'hff0;
  localparam logic [11:0] GREEN  = 12'h0f0;
  localparam logic [11:0] CYAN   = 12'h0ff;
  localparam logic [11:0] BLUE   = 12'h00f;
  localparam logic [11:0] PURPLE = 12'hf0f;
  localparam logic [11:0] BLACK  = 12'h000;
  localparam logic [11:0] WHITE  = 12'hfff;
  localparam logic [11:0] GRAY   = 12'h444;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // Row-major linear address; callers truncate to their own address width.
  function automatic logic [31:0] addr_of(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input int unsigned h_valid);
    return 32'(y) * h_valid + 32'(x);
  endfunction

  function automatic logic [11:0] default_rgb(input int unsigned idx);
    logic [11:0] rgb;
    case (idx)
      0:       rgb = RED;
      1:       rgb = ORANGE;
      2:       rgb = YELLOW;
      3:       rgb = GREEN;
      4:       rgb = CYAN;
      5:       rgb = BLUE;
      6:       rgb = PURPLE;
      7:       rgb = BLACK;
      8:       rgb = WHITE;
      9:       rgb = GRAY;
      default: rgb = BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read-first
// read port, power-up contents set to a fixed colour index.
module vga_fb_ram #(
  parameter int                DEPTH  = 307200,
  parameter int                ADDR_W = 19,
  parameter int                DATA_W = 4,
  parameter logic [DATA_W-1:0] INIT   = '0
) (
  input  logic              vga_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT};

  // The read samples the array before this edge's write lands (read-first).
  always_ff @(posedge vga_clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Indexed-colour framebuffer with a rectangle/clear fill engine, a writable
// palette and a two-stage display read path feeding the VGA timing block.
module vga_rect_fill
  import vga_pkg::*;
#(
  parameter int H_VALID = H_VALID_DEF,
  parameter int V_VALID = V_VALID_DEF,
  parameter int IDX_W   = 4,
  parameter int PIX_W   = 12,
  parameter int BG_IDX  = 7,
  parameter int COORD_W = 10
) (
  input  logic               vga_clk,
  input  logic               sys_rst,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic [PIX_W-1:0]   pix_data,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_clear,
  input  logic [COORD_W-1:0] cmd_x_start,
  input  logic [COORD_W-1:0] cmd_x_end,
  input  logic [COORD_W-1:0] cmd_y_start,
  input  logic [COORD_W-1:0] cmd_y_end,
  input  logic [IDX_W-1:0]   cmd_color,
  output logic               busy,
  output logic               done,
  input  logic               pal_we,
  input  logic [IDX_W-1:0]   pal_addr,
  input  logic [PIX_W-1:0]   pal_wdata
);

  localparam int                 ADDR_W = $clog2(H_VALID * V_VALID);
  localparam int                 PAL_N  = 2 ** IDX_W;
  localparam logic [COORD_W-1:0] H_LIM  = COORD_W'(H_VALID);
  localparam logic [COORD_W-1:0] V_LIM  = COORD_W'(V_VALID);
  localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
  localparam logic [IDX_W-1:0]   BG     = IDX_W'(BG_IDX);

  fill_state_t        state, state_nxt;
  logic [COORD_W-1:0] cur_x, cur_x_nxt;
  logic [COORD_W-1:0] cur_y, cur_y_nxt;
  logic [COORD_W-1:0] x_lo, x_lo_nxt;
  logic [COORD_W-1:0] x_hi, x_hi_nxt;
  logic [COORD_W-1:0] y_hi, y_hi_nxt;
  logic [IDX_W-1:0]   fill_idx, fill_idx_nxt;

  logic [COORD_W-1:0] clip_xs, clip_xe, clip_ys, clip_ye;
  logic [IDX_W-1:0]   clip_idx;
  logic               clip_empty;

  logic               fb_we;
  logic [ADDR_W-1:0]  fb_wr_addr;
  logic [ADDR_W-1:0]  fb_rd_addr;
  logic [IDX_W-1:0]   fb_rd_idx;
  logic               pix_vis;
  logic               vis_q;

  logic [PIX_W-1:0]   palette [PAL_N];

  // Command clipping: ends are limited to the visible area, a clear covers it all.
  always_comb begin
    clip_xs  = cmd_x_start;
    clip_xe  = (cmd_x_end > H_LIM) ? H_LIM : cmd_x_end;
    clip_ys  = cmd_y_start;
    clip_ye  = (cmd_y_end > V_LIM) ? V_LIM : cmd_y_end;
    clip_idx = cmd_color;
    if (cmd_clear) begin
      clip_xs  = '0;
      clip_xe  = H_LIM;
      clip_ys  = '0;
      clip_ye  = V_LIM;
      clip_idx = BG;
    end
    clip_empty = (clip_xs >= clip_xe) || (clip_ys >= clip_ye);
  end

  always_comb begin
    state_nxt    = state;
    cur_x_nxt    = cur_x;
    cur_y_nxt    = cur_y;
    x_lo_nxt     = x_lo;
    x_hi_nxt     = x_hi;
    y_hi_nxt     = y_hi;
    fill_idx_nxt = fill_idx;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cur_x_nxt    = clip_xs;
          cur_y_nxt    = clip_ys;
          x_lo_nxt     = clip_xs;
          x_hi_nxt     = clip_xe;
          y_hi_nxt     = clip_ye;
          fill_idx_nxt = clip_idx;
          state_nxt    = clip_empty ? DONE : FILL;
        end
      end
      FILL: begin
        if (cur_x == x_hi - ONE) begin
          cur_x_nxt = x_lo;
          if (cur_y == y_hi - ONE) begin
            state_nxt = DONE;
          end else begin
            cur_y_nxt = cur_y + ONE;
          end
        end else begin
          cur_x_nxt = cur_x + ONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      cur_x    <= '0;
      cur_y    <= '0;
      x_lo     <= '0;
      x_hi     <= '0;
      y_hi     <= '0;
      fill_idx <= '0;
    end else begin
      state    <= state_nxt;
      cur_x    <= cur_x_nxt;
      cur_y    <= cur_y_nxt;
      x_lo     <= x_lo_nxt;
      x_hi     <= x_hi_nxt;
      y_hi     <= y_hi_nxt;
      fill_idx <= fill_idx_nxt;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // A reset arriving mid-fill must not sneak one more pixel into the frame.
  assign fb_we      = (state == FILL) && !sys_rst;
  assign fb_wr_addr = ADDR_W'(addr_of(16'(cur_x), 16'(cur_y), H_VALID));
  assign pix_vis    = (pix_x < H_LIM) && (pix_y < V_LIM);
  assign fb_rd_addr = pix_vis ? ADDR_W'(addr_of(16'(pix_x), 16'(pix_y), H_VALID)) : '0;

  vga_fb_ram #(
    .DEPTH  (H_VALID * V_VALID),
    .ADDR_W (ADDR_W),
    .DATA_W (IDX_W),
    .INIT   (BG)
  ) u_fb_ram (
    .vga_clk (vga_clk),
    .we      (fb_we),
    .wr_addr (fb_wr_addr),
    .wr_data (fill_idx),
    .rd_addr (fb_rd_addr),
    .rd_data (fb_rd_idx)
  );

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < PAL_N; i++) begin
        palette[i] <= PIX_W'(default_rgb(i));
      end
    end else if (pal_we) begin
      palette[pal_addr] <= pal_wdata;
    end
  end

  // Second display stage: blanking bypasses the palette and outputs black.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      vis_q    <= 1'b0;
      pix_data <= '0;
    end else begin
      vis_q    <= pix_vis;
      pix_data <= vis_q ? palette[fb_rd_idx] : '0;
    end
  end

endmodule
